// File: rtl/csr_irq_ctrl.sv
// csr_irq_ctrl: machine-mode CSRs and prioritised interrupt entry; define CSR_IRQ_SYNC_EN to add 2-flop input synchronisers
module csr_irq_ctrl #(
  parameter int NUM_LOCAL = 4,
  parameter int HOLDOFF   = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [31:0]          pc_i,
  input  logic [11:0]          csr_raddr_i,
  output logic [31:0]          csr_rdata_o,
  input  logic [11:0]          csr_waddr_i,
  input  logic [31:0]          csr_wdata_i,
  input  logic                 csr_wen_i,
  input  logic [1:0]           csr_op_i,
  input  logic                 meip_i,
  input  logic                 mtip_i,
  input  logic [NUM_LOCAL-1:0] irq_i,
  input  logic                 mret_i,
  output logic                 trap_o,
  output logic [31:0]          trap_addr_o,
  output logic [31:0]          mepc_o,
  output logic [NUM_LOCAL+1:0] ack_o
);
  localparam int NI = NUM_LOCAL + 2;
  localparam logic [31:0] MIE_MASK = 32'h880 | (((32'h1 << NUM_LOCAL) - 32'h1) << 16);
  typedef enum logic [1:0] {S_IDLE, S_TRAP, S_WAIT} state_t;
  state_t state;
  logic [2:0] cnt;
  logic st_mie, st_mpie;
  logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [NI-1:0] raw, src_in, src_q, pend, onehot;
  logic [31:0] mstatus_v, mip_v, old_v, new_v;
  logic [4:0] cause;
  logic take, we;
  assign raw = {irq_i, mtip_i, meip_i};
`ifdef CSR_IRQ_SYNC_EN
  logic [NI-1:0] sync1, sync2;
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  assign src_in = sync2;
`else
  assign src_in = raw;
`endif
  assign mstatus_v = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
  assign mip_v     = {16'(src_q[NI-1:2]), 4'b0, src_q[0], 3'b0, src_q[1], 7'b0};
  assign pend      = src_q & {mie_q[16 +: NUM_LOCAL], mie_q[7], mie_q[11]};
  assign onehot    = pend & (~pend + 1'b1);
  assign take      = state == S_IDLE && st_mie && |pend && !mret_i;
  assign we        = csr_wen_i && csr_op_i != 2'b11 && !take;
  assign mepc_o    = mepc_q;
  assign trap_addr_o = {mtvec_q[31:2], 2'b00} + (mtvec_q[0] ? {mcause_q[29:0], 2'b00} : 32'h0);
  function automatic logic [31:0] rd(input logic [11:0] a);
    case (a)
      12'h300: rd = mstatus_v;
      12'h304: rd = mie_q;
      12'h305: rd = mtvec_q;
      12'h340: rd = mscratch_q;
      12'h341: rd = mepc_q;
      12'h342: rd = mcause_q;
      12'h344: rd = mip_v;
      default: rd = 32'h0;
    endcase
  endfunction
  always_comb begin
    old_v = rd(csr_waddr_i);
    new_v = csr_op_i == 2'b00 ? csr_wdata_i : csr_op_i == 2'b01 ? old_v | csr_wdata_i : old_v & ~csr_wdata_i;
  end
  // lowest set bit of pend wins, matching MEI > MTI > local 0 > ...
  always_comb begin
    cause = 5'd0;
    for (int k = NI - 1; k >= 0; k--)
      if (pend[k]) cause = k == 0 ? 5'd11 : k == 1 ? 5'd7 : 5'(k + 14);
  end
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      state       <= S_IDLE;
      cnt         <= '0;
      csr_rdata_o <= '0;
      trap_o      <= 1'b0;
      ack_o       <= '0;
      st_mie      <= 1'b0;
      st_mpie     <= 1'b0;
      mie_q       <= '0;
      mtvec_q     <= '0;
      mscratch_q  <= '0;
      mepc_q      <= '0;
      mcause_q    <= '0;
      src_q       <= '0;
    end else begin
      csr_rdata_o <= rd(csr_raddr_i);
      src_q       <= src_in;
      if (we)
        case (csr_waddr_i)
          12'h300: if (!mret_i) {st_mpie, st_mie} <= {new_v[7], new_v[3]};
          12'h304: mie_q <= new_v & MIE_MASK;
          12'h305: mtvec_q <= {new_v[31:2], new_v[1] ? mtvec_q[1:0] : new_v[1:0]};
          12'h340: mscratch_q <= new_v;
          12'h341: mepc_q <= new_v & ~32'h3;
          12'h342: mcause_q <= new_v;
          default: ;
        endcase
      if (mret_i) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end
      case (state)
        S_IDLE:
          if (take) begin
            state    <= S_TRAP;
            mepc_q   <= pc_i & ~32'h3;
            st_mpie  <= st_mie;
            st_mie   <= 1'b0;
            mcause_q <= {1'b1, 26'b0, cause};
            ack_o    <= onehot;
            trap_o   <= 1'b1;
          end
        S_TRAP: begin
          state  <= S_WAIT;
          cnt    <= '0;
          trap_o <= 1'b0;
          ack_o  <= '0;
        end
        default: begin
          state <= cnt == 3'(HOLDOFF - 1) ? S_IDLE : S_WAIT;
          cnt   <= cnt + 3'd1;
        end
      endcase
    end
endmodule

// File: tb/tb_csr_irq_ctrl.sv
// tb_csr_irq_ctrl: directed vector table for CSR ops plus hand sequences for trap entry, priority, mret and reset
module tb_csr_irq_ctrl;
  logic        clk_i, reset_i, csr_wen_i, meip_i, mtip_i, mret_i, trap_o;
  logic [31:0] pc_i, csr_rdata_o, csr_wdata_i, trap_addr_o, mepc_o;
  logic [11:0] csr_raddr_i, csr_waddr_i;
  logic [1:0]  csr_op_i;
  logic [3:0]  irq_i;
  logic [5:0]  ack_o;
  int checks = 0, errors = 0;
  logic [31:0] r;
  typedef struct {logic [11:0] a; logic [31:0] d; logic [1:0] op; logic [31:0] exp;} vec_t;
  vec_t v[17];

  csr_irq_ctrl #(.NUM_LOCAL(4), .HOLDOFF(2)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .pc_i(pc_i), .csr_raddr_i(csr_raddr_i),
    .csr_rdata_o(csr_rdata_o), .csr_waddr_i(csr_waddr_i), .csr_wdata_i(csr_wdata_i),
    .csr_wen_i(csr_wen_i), .csr_op_i(csr_op_i), .meip_i(meip_i), .mtip_i(mtip_i),
    .irq_i(irq_i), .mret_i(mret_i), .trap_o(trap_o), .trap_addr_o(trap_addr_o),
    .mepc_o(mepc_o), .ack_o(ack_o));

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d, input logic [1:0] op);
    @(negedge clk_i);
    csr_wen_i = 1'b1; csr_waddr_i = a; csr_wdata_i = d; csr_op_i = op;
    @(negedge clk_i);
    csr_wen_i = 1'b0;
  endtask

  task automatic csr_rd(input logic [11:0] a, output logic [31:0] d);
    @(negedge clk_i);
    csr_raddr_i = a;
    @(posedge clk_i);
    #1 d = csr_rdata_o;
  endtask

  task automatic do_mret();
    @(negedge clk_i);
    mret_i = 1'b1;
    @(negedge clk_i);
    mret_i = 1'b0;
  endtask

  task automatic wait_trap(input string n);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_i);
      #1;
      if (trap_o) break;
    end
    chk(n, 32'(trap_o), 32'h1);
  endtask

  initial begin
    v[0]  = '{12'h304, 32'h00000800, 2'b00, 32'h00000800};
    v[1]  = '{12'h304, 32'h00010000, 2'b01, 32'h00010800};
    v[2]  = '{12'h304, 32'h00000800, 2'b10, 32'h00010000};
    v[3]  = '{12'h304, 32'hFFFFFFFF, 2'b00, 32'h000F0880};
    v[4]  = '{12'h305, 32'h00000101, 2'b00, 32'h00000101};
    v[5]  = '{12'h305, 32'h00000203, 2'b00, 32'h00000201};
    v[6]  = '{12'h305, 32'h00000402, 2'b00, 32'h00000401};
    v[7]  = '{12'h305, 32'h00000001, 2'b10, 32'h00000400};
    v[8]  = '{12'h340, 32'hDEADBEEF, 2'b00, 32'hDEADBEEF};
    v[9]  = '{12'h340, 32'hFFFF0000, 2'b10, 32'h0000BEEF};
    v[10] = '{12'h341, 32'h12345677, 2'b00, 32'h12345674};
    v[11] = '{12'h342, 32'h8000000B, 2'b00, 32'h8000000B};
    v[12] = '{12'h300, 32'hFFFFFFFF, 2'b00, 32'h00001888};
    v[13] = '{12'h300, 32'h00000088, 2'b10, 32'h00001800};
    v[14] = '{12'h300, 32'h00000008, 2'b11, 32'h00001800};
    v[15] = '{12'h344, 32'hFFFFFFFF, 2'b00, 32'h00000000};
    v[16] = '{12'h7C0, 32'hFFFFFFFF, 2'b00, 32'h00000000};
    reset_i = 1'b0; pc_i = '0; csr_raddr_i = '0; csr_waddr_i = '0; csr_wdata_i = '0;
    csr_wen_i = 1'b0; csr_op_i = 2'b11; meip_i = 1'b0; mtip_i = 1'b0; irq_i = '0; mret_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_rdata", csr_rdata_o, 32'h0);
    chk("rst_trap", 32'(trap_o), 32'h0);
    chk("rst_ack", 32'(ack_o), 32'h0);
    chk("rst_mepc", mepc_o, 32'h0);
    reset_i = 1'b1;
    csr_rd(12'h300, r); chk("rst_mstatus", r, 32'h00001800);
    csr_rd(12'h344, r); chk("rst_mip", r, 32'h0);
    csr_rd(12'h305, r); chk("rst_mtvec", r, 32'h0);
    csr_rd(12'h7C0, r); chk("rst_unmapped", r, 32'h0);
    for (int i = 0; i < 17; i++) begin
      csr_wr(v[i].a, v[i].d, v[i].op);
      csr_rd(v[i].a, r);
      chk($sformatf("vec%0d", i), r, v[i].exp);
    end
    // same-cycle read sees the pre-write value
    @(negedge clk_i);
    csr_raddr_i = 12'h342; csr_wen_i = 1'b1; csr_waddr_i = 12'h342; csr_wdata_i = 32'h3; csr_op_i = 2'b00;
    @(posedge clk_i);
    #1 chk("rd_before_wr", csr_rdata_o, 32'h8000000B);
    @(negedge clk_i);
    csr_wen_i = 1'b0;
    // single external interrupt, vectored mode
    csr_wr(12'h305, 32'h00000101, 2'b00);
    csr_wr(12'h304, 32'h00000800, 2'b00);
    pc_i = 32'h80;
    csr_wr(12'h300, 32'h00000008, 2'b00);
    meip_i = 1'b1;
    wait_trap("mei_trap");
    chk("mei_ack", 32'(ack_o), 32'h1);
    chk("mei_addr", trap_addr_o, 32'h12C);
    chk("mei_mepc", mepc_o, 32'h80);
    meip_i = 1'b0;
    @(posedge clk_i);
    #1 chk("trap_clear", 32'(trap_o), 32'h0);
    chk("ack_clear", 32'(ack_o), 32'h0);
    csr_rd(12'h342, r); chk("mei_mcause", r, 32'h8000000B);
    csr_rd(12'h300, r); chk("mei_mstatus", r, 32'h00001880);
    // priority: all four sources high
    csr_wr(12'h304, 32'h00030880, 2'b00);
    meip_i = 1'b1; mtip_i = 1'b1; irq_i = 4'b0011;
    do_mret();
    wait_trap("pri_mei_trap");
    chk("pri_mei_ack", 32'(ack_o), 32'h1);
    meip_i = 1'b0;
    repeat (4) @(negedge clk_i);
    do_mret();
    csr_wen_i = 1'b1; csr_waddr_i = 12'h340; csr_wdata_i = 32'h55; csr_op_i = 2'b00;
    wait_trap("pri_mti_trap");
    chk("pri_mti_ack", 32'(ack_o), 32'h2);
    chk("pri_mti_addr", trap_addr_o, 32'h11C);
    @(negedge clk_i);
    csr_wen_i = 1'b0;
    csr_rd(12'h342, r); chk("pri_mti_mcause", r, 32'h80000007);
    csr_rd(12'h340, r); chk("trap_drops_wr", r, 32'h0000BEEF);
    mtip_i = 1'b0;
    repeat (4) @(negedge clk_i);
    do_mret();
    wait_trap("pri_l0_trap");
    chk("pri_l0_ack", 32'(ack_o), 32'h4);
    chk("pri_l0_addr", trap_addr_o, 32'h140);
    csr_rd(12'h342, r); chk("pri_l0_mcause", r, 32'h80000010);
    // mret held two cycles: second cycle has MIE=1 and a pending irq, but no trap
    pc_i = 32'h203;
    repeat (4) @(negedge clk_i);
    @(negedge clk_i);
    mret_i = 1'b1;
    @(posedge clk_i);
    #1 chk("mret1_notrap", 32'(trap_o), 32'h0);
    @(negedge clk_i);
    csr_wen_i = 1'b1; csr_waddr_i = 12'h300; csr_wdata_i = 32'h0; csr_op_i = 2'b00;
    @(posedge clk_i);
    #1 chk("mret2_notrap", 32'(trap_o), 32'h0);
    @(negedge clk_i);
    mret_i = 1'b0; csr_wen_i = 1'b0;
    @(posedge clk_i);
    #1 chk("after_mret_trap", 32'(trap_o), 32'h1);
    chk("after_mret_ack", 32'(ack_o), 32'h4);
    chk("after_mret_mepc", mepc_o, 32'h200);
    // asynchronous reset during TRAP
    reset_i = 1'b0;
    #1 chk("rst_mid_trap", 32'(trap_o), 32'h0);
    chk("rst_mid_ack", 32'(ack_o), 32'h0);
    chk("rst_mid_mepc", mepc_o, 32'h0);
    @(negedge clk_i);
    reset_i = 1'b1;
    csr_rd(12'h300, r); chk("rst_mid_mstatus", r, 32'h00001800);
    @(posedge clk_i);
    #1 chk("rst_mid_idle", 32'(trap_o), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
